// File: rtl/bp_pkg.sv
// Shared definitions for the branch history predictor: default counter
// ceiling/reset values, saturating counter arithmetic and the table index hash.
package bp_pkg;

    localparam int CTR_W_DEFAULT = 2;
    localparam int CTR_MAX       = (1 << CTR_W_DEFAULT) - 1;
    localparam int CTR_INIT      = 0;

    // Increment that sticks at the ceiling instead of wrapping to zero.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max);
        return (val >= max) ? max : val + 1;
    endfunction

    // Decrement that sticks at zero instead of wrapping to the ceiling.
    function automatic int unsigned sat_dec(input int unsigned val);
        return (val == 0) ? 0 : val - 1;
    endfunction

    // Bimodal uses the PC slice alone; gshare folds the history into it.
    function automatic logic [31:0] idx_hash(input logic [31:0] base,
                                             input logic [31:0] hist,
                                             input logic        gshare);
        return gshare ? (base ^ hist) : base;
    endfunction

endpackage

// File: rtl/sat_counter_bank.sv
// Table of saturating counters with one combinational read port and one
// read-modify-write update port. The update direction is passed in, and the
// bank applies the saturating step itself.
module sat_counter_bank #(
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int CTR_RESET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);
    import bp_pkg::*;

    localparam int DEPTH = 1 << IDX_W;
    localparam int unsigned LIMIT = (1 << CTR_W) - 1;

    logic [CTR_W-1:0] ctr [DEPTH];
    logic [CTR_W-1:0] wr_old;
    logic [CTR_W-1:0] wr_new;

    assign rd_ctr = ctr[rd_idx];

    // Next value of the entry being trained, saturating in either direction.
    always_comb begin
        wr_old = ctr[wr_idx];
        wr_new = wr_old;
        if (wr_up) begin
            wr_new = CTR_W'(sat_inc(32'(wr_old), LIMIT));
        end else begin
            wr_new = CTR_W'(sat_dec(32'(wr_old)));
        end
    end

    // Counter storage: reset every entry, otherwise write back the trained entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_W'(CTR_RESET);
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_new;
        end
    end

endmodule

// File: rtl/branch_history_predictor.sv
// Table-of-counters branch predictor. Fetch requests get a registered
// prediction one cycle later; resolved branches train the table. In gshare
// mode a global history register is shifted speculatively on each request
// and repaired from the caller-returned snapshot on a mispredict.
module branch_history_predictor #(
    parameter int PC_W     = 32,
    parameter int IDX_W    = 6,
    parameter int IDX_LSB  = 2,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 6,
    parameter int GSHARE   = 0,
    parameter int CTR_INIT = bp_pkg::CTR_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic [PC_W-1:0]   req_pc,
    output logic              prediction,
    output logic              pred_valid,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              result,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [HIST_W-1:0] res_ghr,
    input  logic              taken,
    input  logic              mispredict
);
    import bp_pkg::*;

    localparam logic USE_GSHARE = (GSHARE != 0);

    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  req_base;
    logic [IDX_W-1:0]  res_base;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  res_idx;
    logic [CTR_W-1:0]  rd_ctr;
    logic              pred_bit;
    logic              unused_inputs;

    assign req_base = req_pc[IDX_LSB+IDX_W-1:IDX_LSB];
    assign res_base = res_pc[IDX_LSB+IDX_W-1:IDX_LSB];
    assign req_idx  = IDX_W'(idx_hash(32'(req_base), 32'(ghr), USE_GSHARE));
    assign res_idx  = IDX_W'(idx_hash(32'(res_base), 32'(res_ghr), USE_GSHARE));
    assign pred_bit = rd_ctr[CTR_W-1];

    // Only the index slice of each PC matters; the rest is deliberately ignored.
    assign unused_inputs = ^{req_pc, res_pc, res_ghr, mispredict};

    sat_counter_bank #(
        .IDX_W     (IDX_W),
        .CTR_W     (CTR_W),
        .CTR_RESET (CTR_INIT)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (req_idx),
        .rd_ctr (rd_ctr),
        .wr_en  (result),
        .wr_idx (res_idx),
        .wr_up  (taken)
    );

    generate
        if (GSHARE != 0) begin : g_ghr
            // History register: mispredict repair beats the speculative shift.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ghr <= '0;
                end else if (result && mispredict) begin
                    ghr <= HIST_W'({res_ghr, taken});
                end else if (request) begin
                    ghr <= HIST_W'({ghr, pred_bit});
                end
            end
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

    // Output registers: the counter is read before any same-cycle update lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            prediction <= 1'b0;
            pred_valid <= 1'b0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= request;
            if (request) begin
                prediction <= pred_bit;
                pred_ghr   <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for branch_history_predictor: one bimodal and one gshare
// instance, each driven by its own stimulus signals, sharing clock and reset.
module tb_branch_history_predictor;

    logic        clk = 1'b0;
    logic        rst;

    logic        b_request, b_result, b_taken, b_mispredict;
    logic [31:0] b_req_pc, b_res_pc;
    logic [5:0]  b_res_ghr;
    logic        b_prediction, b_pred_valid;
    logic [5:0]  b_pred_ghr;

    logic        g_request, g_result, g_taken, g_mispredict;
    logic [31:0] g_req_pc, g_res_pc;
    logic [5:0]  g_res_ghr;
    logic        g_prediction, g_pred_valid;
    logic [5:0]  g_pred_ghr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_history_predictor #(.GSHARE(0)) dut_bi (
        .clk        (clk),
        .rst        (rst),
        .request    (b_request),
        .req_pc     (b_req_pc),
        .prediction (b_prediction),
        .pred_valid (b_pred_valid),
        .pred_ghr   (b_pred_ghr),
        .result     (b_result),
        .res_pc     (b_res_pc),
        .res_ghr    (b_res_ghr),
        .taken      (b_taken),
        .mispredict (b_mispredict)
    );

    branch_history_predictor #(.GSHARE(1)) dut_gs (
        .clk        (clk),
        .rst        (rst),
        .request    (g_request),
        .req_pc     (g_req_pc),
        .prediction (g_prediction),
        .pred_valid (g_pred_valid),
        .pred_ghr   (g_pred_ghr),
        .result     (g_result),
        .res_pc     (g_res_pc),
        .res_ghr    (g_res_ghr),
        .taken      (g_taken),
        .mispredict (g_mispredict)
    );

    // One clock of bimodal stimulus; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic req, input logic [31:0] rpc,
                                 input logic res, input logic [31:0] spc, input logic tk);
        b_request = req;
        b_req_pc  = rpc;
        b_result  = res;
        b_res_pc  = spc;
        b_taken   = tk;
        @(posedge clk);
        #1;
        b_request = 1'b0;
        b_result  = 1'b0;
    endtask

    // One clock of gshare stimulus; returns 1 time unit after the edge.
    task automatic applyStimulusGs(input logic req, input logic [31:0] rpc,
                                   input logic res, input logic [31:0] spc,
                                   input logic [5:0] rghr, input logic tk, input logic mis);
        g_request    = req;
        g_req_pc     = rpc;
        g_result     = res;
        g_res_pc     = spc;
        g_res_ghr    = rghr;
        g_taken      = tk;
        g_mispredict = mis;
        @(posedge clk);
        #1;
        g_request    = 1'b0;
        g_result     = 1'b0;
        g_mispredict = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        b_request = 0; b_result = 0; b_taken = 0; b_mispredict = 0;
        b_req_pc = 0; b_res_pc = 0; b_res_ghr = 0;
        g_request = 0; g_result = 0; g_taken = 0; g_mispredict = 0;
        g_req_pc = 0; g_res_pc = 0; g_res_ghr = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(b_pred_valid), 0);
        checkOutput("rst_pred",  32'(b_prediction), 0);
        checkOutput("rst_ghr",   32'(g_pred_ghr),   0);
        rst = 1'b0;

        // First request after reset: counter at init, no history.
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("req1_valid", 32'(b_pred_valid), 1);
        checkOutput("req1_pred",  32'(b_prediction), 0);
        checkOutput("req1_ghr",   32'(b_pred_ghr),   0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_valid", 32'(b_pred_valid), 0);

        // Train 0x40 taken four times: 1,2,3, then saturates at 3.
        repeat (4) applyStimulus(0, 0, 1, 32'h40, 1);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("sat_hi_pred", 32'(b_prediction), 1);
        applyStimulus(0, 0, 1, 32'h40, 0);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("nt1_pred", 32'(b_prediction), 1);
        applyStimulus(0, 0, 1, 32'h40, 0);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("nt2_pred", 32'(b_prediction), 0);

        // Aliasing: 0x140 maps to the same entry as 0x40 (counter now 1).
        applyStimulus(1, 32'h140, 0, 0, 0);
        checkOutput("alias_pre", 32'(b_prediction), 0);
        applyStimulus(0, 0, 1, 32'h140, 1);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("alias_post", 32'(b_prediction), 1);

        // Same-cycle request and result on 0x80 with counter at 1.
        applyStimulus(0, 0, 1, 32'h80, 1);
        applyStimulus(1, 32'h80, 1, 32'h80, 1);
        checkOutput("rbw_pred", 32'(b_prediction), 0);
        applyStimulus(1, 32'h80, 0, 0, 0);
        checkOutput("rbw_next", 32'(b_prediction), 1);

        // Same-cycle request and result on different entries.
        applyStimulus(1, 32'h40, 1, 32'hC0, 1);
        checkOutput("diff_pred", 32'(b_prediction), 1);
        applyStimulus(1, 32'hC0, 0, 0, 0);
        checkOutput("diff_res", 32'(b_prediction), 0);

        // Reset the cycle after a request, with another request pending.
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("pre_rst_pred", 32'(b_prediction), 1);
        rst = 1'b1;
        applyStimulus(1, 32'h40, 0, 0, 0);
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(b_pred_valid), 0);
        checkOutput("mid_rst_pred",  32'(b_prediction), 0);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("post_rst_40", 32'(b_prediction), 0);
        applyStimulus(1, 32'h80, 0, 0, 0);
        checkOutput("post_rst_80", 32'(b_prediction), 0);

        // Underflow: not-taken at 0 stays 0, then two takens reach 2.
        applyStimulus(0, 0, 1, 32'h40, 0);
        applyStimulus(0, 0, 1, 32'h40, 1);
        applyStimulus(0, 0, 1, 32'h40, 1);
        applyStimulus(1, 32'h40, 0, 0, 0);
        checkOutput("underflow_pred", 32'(b_prediction), 1);

        // Gshare: train idx 0x20 (hist 0) and idx 0x31 (hist 1) to weakly taken.
        repeat (2) applyStimulusGs(0, 0, 1, 32'h80, 6'd0, 1, 0);
        repeat (2) applyStimulusGs(0, 0, 1, 32'hC0, 6'd1, 1, 0);
        applyStimulusGs(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("gs_p0",     32'(g_prediction), 0);
        checkOutput("gs_p0_ghr", 32'(g_pred_ghr),   0);
        applyStimulusGs(1, 32'h80, 0, 0, 0, 0, 0);
        checkOutput("gs_p1",     32'(g_prediction), 1);
        applyStimulusGs(1, 32'hC0, 0, 0, 0, 0, 0);
        checkOutput("gs_p2",     32'(g_prediction), 1);
        checkOutput("gs_p2_ghr", 32'(g_pred_ghr),   32'h01);
        applyStimulusGs(1, 32'h00, 0, 0, 0, 0, 0);
        checkOutput("gs_ghr_011", 32'(g_pred_ghr), 32'h03);

        // Repair with concurrent request: request sees pre-repair history.
        applyStimulusGs(1, 32'h00, 1, 32'h100, 6'd1, 0, 1);
        checkOutput("gs_conc_ghr", 32'(g_pred_ghr), 32'h06);
        applyStimulusGs(1, 32'h00, 0, 0, 0, 0, 0);
        checkOutput("gs_repair", 32'(g_pred_ghr), 32'h02);

        // Correctly predicted result must not touch the history.
        applyStimulusGs(0, 0, 1, 32'h00, 6'd0, 1, 0);
        applyStimulusGs(1, 32'h00, 0, 0, 0, 0, 0);
        checkOutput("gs_no_repair", 32'(g_pred_ghr), 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
